// File: rtl/spi_master_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master_gen : synchronous SPI master, CPOL/CPHA, MSB/LSB-first, N-bit |
// | Optional burst CS hold: define SPI_MASTER_GEN_BURST_EN                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_master_gen #(
    parameter int SLAVE_COUNT = 8,
    parameter int MAX_WIDTH   = 32,
    parameter int DIV_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           ready,
    output logic                           done,
    input  logic [MAX_WIDTH-1:0]           tx_data,
    output logic [MAX_WIDTH-1:0]           rx_data,
    input  logic [$clog2(MAX_WIDTH)-1:0]   word_len,
    input  logic [$clog2(SLAVE_COUNT)-1:0] chip_addrs,
    input  logic [DIV_W-1:0]               clk_div,
    input  logic                           CPOL,
    input  logic                           CPHA,
    input  logic                           lsb_first,
    input  logic                           default_val,
`ifdef SPI_MASTER_GEN_BURST_EN
    input  logic                           hold_cs,
`endif
    output logic                           MOSI,
    input  logic                           MISO,
    output logic                           SPI_SCLK,
    output logic [SLAVE_COUNT-1:0]         CS
);

    localparam int LW = $clog2(MAX_WIDTH);
    localparam int AW = $clog2(SLAVE_COUNT);
    localparam int EW = $clog2(2*MAX_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        SHIFT      = 3'd2,
        HOLD       = 3'd3,
        GAP        = 3'd4,
        BURST_WAIT = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d, div_q, div_d;
    logic [EW-1:0]          edge_q, edge_d;
    logic [LW-1:0]          wl_q, wl_d, idx_q, idx_d;
    logic [MAX_WIDTH-1:0]   tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [SLAVE_COUNT-1:0] cs_q, cs_d;
    logic                   sclk_q, sclk_d, mosi_q, mosi_d;
    logic                   cpha_q, cpha_d, lsb_q, lsb_d, dflt_q, dflt_d;
    logic                   done_q, done_d;

    logic                   w_tick, w_accept, w_odd, w_hold;
    logic [EW-1:0]          w_edge, w_last_edge;
    logic [LW-1:0]          w_next_idx, w_first_idx;
    logic [SLAVE_COUNT-1:0] w_cs_sel;

`ifdef SPI_MASTER_GEN_BURST_EN
    logic hold_q, hold_d;
    assign w_hold = hold_q;
`else
    assign w_hold = 1'b0;
`endif

    generate
        for (genvar g = 0; g < SLAVE_COUNT; g++) begin : g_cs_dec
            assign w_cs_sel[g] = (chip_addrs == AW'(g));
        end
    endgenerate

    assign ready       = (state_q == IDLE) || (state_q == BURST_WAIT);
    assign w_accept    = start & ready;
    assign w_tick      = (cnt_q == '0);
    assign w_edge      = edge_q + 1'b1;
    assign w_odd       = w_edge[0];
    assign w_last_edge = EW'({wl_q, 1'b0}) + EW'(2);
    assign w_next_idx  = lsb_q ? (idx_q + 1'b1) : (idx_q - 1'b1);
    assign w_first_idx = lsb_first ? '0 : word_len;

    // Outside a word the line levels follow the live CPOL/default_val inputs
    assign SPI_SCLK = (state_q == IDLE) ? CPOL : sclk_q;
    assign MOSI     = (state_q == IDLE) ? default_val : mosi_q;
    assign CS       = cs_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        edge_d    = edge_q;
        wl_d      = wl_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        dflt_d    = dflt_q;
        done_d    = 1'b0;
`ifdef SPI_MASTER_GEN_BURST_EN
        hold_d    = hold_q;
`endif
        if (w_accept) begin
            tx_d    = tx_data;
            wl_d    = word_len;
            div_d   = clk_div;
            cnt_d   = clk_div;
            cpha_d  = CPHA;
            lsb_d   = lsb_first;
            dflt_d  = default_val;
            idx_d   = w_first_idx;
            edge_d  = '0;
            rx_sh_d = '0;
            sclk_d  = CPOL;
            mosi_d  = CPHA ? default_val : tx_data[w_first_idx];
`ifdef SPI_MASTER_GEN_BURST_EN
            hold_d  = hold_cs;
`endif
            // A burst continuation keeps the already-asserted CS and skips SETUP
            if (state_q == IDLE) begin
                cs_d    = ~w_cs_sel;
                state_d = SETUP;
            end else begin
                state_d = SHIFT;
            end
        end else begin
            case (state_q)
                SETUP, SHIFT: begin
                    if (w_tick) begin
                        cnt_d   = div_q;
                        edge_d  = w_edge;
                        sclk_d  = ~sclk_q;
                        state_d = SHIFT;
                        // Sample edges: odd for CPHA=0, even for CPHA=1
                        if (w_odd ^ cpha_q) begin
                            rx_sh_d[idx_q] = MISO;
                        end else if (w_edge != w_last_edge) begin
                            if (cpha_q && (w_edge == EW'(1))) begin
                                mosi_d = tx_q[idx_q];
                            end else begin
                                idx_d  = w_next_idx;
                                mosi_d = tx_q[w_next_idx];
                            end
                        end
                        if (w_edge == w_last_edge) begin
                            state_d = HOLD;
                            mosi_d  = dflt_q;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        cnt_d     = div_q;
                        done_d    = 1'b1;
                        rx_data_d = rx_sh_q;
                        if (w_hold) begin
                            state_d = BURST_WAIT;
                        end else begin
                            cs_d    = '1;
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            wl_q      <= '0;
            idx_q     <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            cs_q      <= '1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            dflt_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPI_MASTER_GEN_BURST_EN
            hold_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            wl_q      <= wl_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            dflt_q    <= dflt_d;
            done_q    <= done_d;
`ifdef SPI_MASTER_GEN_BURST_EN
            hold_q    <= hold_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_master_gen : directed self-checking bench for spi_master_gen      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_master_gen;

    localparam int SLAVE_COUNT = 8;
    localparam int MAX_WIDTH   = 32;
    localparam int DIV_W       = 8;

    logic        clk = 1'b0;
    logic        rst, start, ready, done;
    logic [31:0] tx_data, rx_data;
    logic [4:0]  word_len;
    logic [2:0]  chip_addrs;
    logic [7:0]  clk_div;
    logic        CPOL, CPHA, lsb_first, default_val;
    logic        MOSI, MISO, SPI_SCLK;
    logic [7:0]  CS;
`ifdef SPI_MASTER_GEN_BURST_EN
    logic        hold_cs;
`endif

    // Slave model state
    logic        use_loop, slave_bit, slave_cpha, slave_lsb;
    logic [31:0] slave_word;
    int          slave_edges, slave_n;

    int n_checks = 0;
    int n_errors = 0;
    int edges_r, cyc_r, dcnt, cs_err;
    logic prev_r;

    always #5 clk = ~clk;

    assign MISO = use_loop ? MOSI : slave_bit;

    // Slave presents bit j ahead of the edge on which the master samples it
    always_comb begin
        int jj, bb;
        jj = slave_cpha ? ((slave_edges == 0) ? 0 : (slave_edges - 1) / 2) : slave_edges / 2;
        if (jj > slave_n - 1) jj = slave_n - 1;
        bb = slave_lsb ? jj : (slave_n - 1 - jj);
        slave_bit = slave_word[bb];
    end

    spi_master_gen #(
        .SLAVE_COUNT (SLAVE_COUNT),
        .MAX_WIDTH   (MAX_WIDTH),
        .DIV_W       (DIV_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ready       (ready),
        .done        (done),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .word_len    (word_len),
        .chip_addrs  (chip_addrs),
        .clk_div     (clk_div),
        .CPOL        (CPOL),
        .CPHA        (CPHA),
        .lsb_first   (lsb_first),
        .default_val (default_val),
`ifdef SPI_MASTER_GEN_BURST_EN
        .hold_cs     (hold_cs),
`endif
        .MOSI        (MOSI),
        .MISO        (MISO),
        .SPI_SCLK    (SPI_SCLK),
        .CS          (CS)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic run_word(input string nm, input logic cpol, input logic cpha, input logic lsb,
                            input int n, input logic [7:0] div, input logic [2:0] addr,
                            input int eaddr, input logic [31:0] tx, input logic dflt,
                            input logic loopb, input logic [31:0] sw, input logic hold,
                            input logic gap_st);
        int t, c, edges, done_at, ready_at, first_at, limit, j, b, dpulses;
        logic [63:0] mask, exp_rx;
        logic [31:0] slave_rx;
        logic prev_sclk, prev_mosi, cs_bad;
        logic [7:0] ecs, ecs_end;
        t    = int'(div) + 1;
        mask = (64'h1 << n) - 64'h1;
        exp_rx = {32'h0, (loopb ? tx : sw)} & mask;
        ecs = 8'hFF;
        ecs[eaddr] = 1'b0;
        ecs_end = hold ? ecs : 8'hFF;
        CPOL = cpol; CPHA = cpha; lsb_first = lsb; word_len = 5'(n - 1);
        clk_div = div; chip_addrs = addr; tx_data = tx; default_val = dflt;
        use_loop = loopb; slave_word = sw; slave_lsb = lsb; slave_n = n;
        slave_cpha = cpha; slave_edges = 0;
`ifdef SPI_MASTER_GEN_BURST_EN
        hold_cs = hold;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0; edges = 0; done_at = -1; ready_at = -1; first_at = -1;
        dpulses = 0; cs_bad = 1'b0; slave_rx = '0;
        check_val({nm, "_cs_e0"}, CS, ecs);
        check_val({nm, "_sclk_e0"}, SPI_SCLK, cpol);
        check_val({nm, "_ready_e0"}, ready, 1'b0);
        prev_sclk = SPI_SCLK;
        prev_mosi = MOSI;
        limit = (2*n + 2) * t + 8;
        while ((done_at < 0 || ready_at < 0) && c < limit) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) begin
                tx_data = ~tx; word_len = ~word_len; clk_div = div ^ 8'h5A;
                chip_addrs = addr + 3'd1; lsb_first = ~lsb;
`ifdef SPI_MASTER_GEN_BURST_EN
                hold_cs = ~hold;
`endif
            end
            if (gap_st && done_at >= 0 && c == done_at + 1) start = 1'b0;
            if (SPI_SCLK !== prev_sclk) begin
                edges++;
                if (first_at < 0) first_at = c;
                if ((edges % 2 == 1) ^ cpha) begin
                    j = cpha ? (edges - 2) / 2 : (edges - 1) / 2;
                    b = lsb ? j : (n - 1 - j);
                    if (j < n) slave_rx[b] = prev_mosi;
                end
                slave_edges = edges;
            end
            prev_sclk = SPI_SCLK;
            prev_mosi = MOSI;
            if (c < (2*n + 1) * t && CS !== ecs) cs_bad = 1'b1;
            if (done) dpulses++;
            if (done && done_at < 0) begin
                done_at = c;
                check_val({nm, "_cs_done"}, CS, ecs_end);
                check_val({nm, "_sclk_done"}, SPI_SCLK, cpol);
                check_val({nm, "_mosi_done"}, MOSI, dflt);
                check_val({nm, "_rx"}, rx_data, exp_rx);
                if (gap_st) start = 1'b1;
            end
            if (ready && ready_at < 0) ready_at = c;
        end
        @(posedge clk); #1;
        if (done) dpulses++;
        check_val({nm, "_edges"}, edges, 2*n);
        check_val({nm, "_first_edge"}, first_at, t);
        check_val({nm, "_done_at"}, done_at, (2*n + 1) * t);
        check_val({nm, "_ready_at"}, ready_at, hold ? (2*n + 1) * t : (2*n + 2) * t);
        check_val({nm, "_done_pulses"}, dpulses, 1);
        check_val({nm, "_cs_during"}, cs_bad, 1'b0);
        check_val({nm, "_mosi_seq"}, {32'h0, slave_rx}, {32'h0, tx} & mask);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_data = '0; word_len = '0; chip_addrs = '0;
        clk_div = '0; CPOL = 1'b1; CPHA = 1'b0; lsb_first = 1'b0; default_val = 1'b1;
        use_loop = 1'b1; slave_word = '0; slave_cpha = 1'b0; slave_lsb = 1'b0;
        slave_n = 1; slave_edges = 0;
`ifdef SPI_MASTER_GEN_BURST_EN
        hold_cs = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_val("por_ready", ready, 1'b1);
        check_val("por_done", done, 1'b0);
        check_val("por_cs", CS, 8'hFF);
        check_val("por_rx", rx_data, 32'h0);
        check_val("por_sclk_cpol1", SPI_SCLK, 1'b1);
        check_val("por_mosi_dflt1", MOSI, 1'b1);
        CPOL = 1'b0; default_val = 1'b0; #1;
        check_val("por_sclk_cpol0", SPI_SCLK, 1'b0);
        check_val("por_mosi_dflt0", MOSI, 1'b0);

        // Reset aborts a 16-bit word after SCLK edge 9
        word_len = 5'd15; clk_div = 8'd0; chip_addrs = 3'd1; tx_data = 32'h0000F00F;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges_r = 0; cyc_r = 0; prev_r = SPI_SCLK;
        while (edges_r < 9 && cyc_r < 100) begin
            @(posedge clk); #1;
            cyc_r++;
            if (SPI_SCLK !== prev_r) edges_r++;
            prev_r = SPI_SCLK;
        end
        check_val("rst_reach_edge9", edges_r, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_cs", CS, 8'hFF);
        check_val("rst_sclk", SPI_SCLK, 1'b0);
        check_val("rst_ready", ready, 1'b1);
        check_val("rst_done", done, 1'b0);
        check_val("rst_rx", rx_data, 32'h0);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check_val("rst_no_done", dcnt, 0);

        run_word("m0_n8", 1'b0, 1'b0, 1'b0, 8, 8'd0, 3'd3, 3, 32'hA5, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        run_word("m3_n16_lsb", 1'b1, 1'b1, 1'b1, 16, 8'd3, 3'd0, 0, 32'h1234, 1'b1, 1'b0, 32'hBEEF, 1'b0, 1'b0);
        run_word("m1_n32", 1'b0, 1'b1, 1'b0, 32, 8'd1, 3'd7, 7, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        run_word("m2_n32", 1'b1, 1'b0, 1'b0, 32, 8'd1, 3'd5, 5, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        run_word("n1_gap", 1'b0, 1'b0, 1'b0, 1, 8'd2, 3'd6, 6, 32'h1, 1'b0, 1'b0, 32'h1, 1'b0, 1'b1);
        dcnt = 0; cs_err = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dcnt++;
            if (CS !== 8'hFF) cs_err++;
        end
        check_val("gap_start_no_done", dcnt, 0);
        check_val("gap_start_no_cs", cs_err, 0);
        run_word("n1_divmax", 1'b1, 1'b0, 1'b1, 1, 8'hFF, 3'd2, 2, 32'h3, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
`ifdef SPI_MASTER_GEN_BURST_EN
        run_word("burst1", 1'b0, 1'b0, 1'b0, 8, 8'd0, 3'd2, 2, 32'h55, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        run_word("burst2", 1'b0, 1'b0, 1'b0, 8, 8'd0, 3'd5, 2, 32'hAA, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
- Next-generation, fully synchronous SPI master.
- Parametrised word width up to MAX_WIDTH, runtime word length, counter-based SCLK divider, all four CPOL/CPHA modes and MSB/LSB-first selection.
- One-cycle done pulse per word; guaranteed CS setup, hold and idle-gap timing.
- Sits between a register/bus front end and up to SLAVE_COUNT slaves, each with its own CS line.
- No derived clocks: everything runs on clk.

Parameters:
- SLAVE_COUNT, 8, number of active-low CS outputs (>=2).
- MAX_WIDTH, 32, maximum bits per word (>=2).
- DIV_W, 8, width of the clk_div input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request a word; accepted only when ready=1
- ready  out  1  high when idle and start is accepted
- done  out  1  one-cycle pulse at word completion
- tx_data  in  MAX_WIDTH  word to send, right-justified
- rx_data  out  MAX_WIDTH  last received word, right-justified, upper bits zero
- word_len  in  $clog2(MAX_WIDTH)  bit count minus 1 (N = word_len+1)
- chip_addrs  in  $clog2(SLAVE_COUNT)  target slave index
- clk_div  in  DIV_W  half-period T = clk_div+1 clk cycles
- CPOL  in  1  clock polarity
- CPHA  in  1  clock phase
- lsb_first  in  1  0: bit N-1 first; 1: bit 0 first
- default_val  in  1  MOSI level when not shifting
- MOSI  out  1  serial data out, registered
- MISO  in  1  serial data in
- SPI_SCLK  out  1  serial clock, registered
- CS  out  SLAVE_COUNT  active-low chip selects

Behaviour:
- Reset values: SPI_SCLK=CPOL (combinational with CPOL while idle), CS=all 1, MOSI=default_val, ready=1, done=0, rx_data=0, state IDLE.
- Reset is legal at any time, including mid-word; it aborts the transfer immediately and no done pulse is produced.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- Timing is relative to edge E0, the clk edge at which start=1 is sampled in IDLE.
- At E0: latch tx_data, word_len, chip_addrs, clk_div, CPOL, CPHA, lsb_first.
  - CS[chip_addrs] goes low; ready goes low; state SETUP.
  - If CPHA=0, MOSI is driven with the first bit.
- SCLK edge k (k=1..2N) toggles at E0+k*T. State is SHIFT from E0+T.
- CPHA=0:
  - MISO is sampled on odd edges, at the same clk edge that toggles SCLK.
  - MOSI advances on even edges, except edge 2N.
- CPHA=1:
  - MOSI advances on odd edges, with the first bit at edge 1.
  - MISO is sampled on even edges.
- Receive order: sampled bits shift in so that rx ends bit-for-bit equal to the transmitted order (MSB-first gives the natural word; lsb_first=1 fills from bit 0 upward).
- At E0+2N*T, SCLK is back at CPOL and the state is HOLD; MOSI=default_val.
- At E0+(2N+1)*T:
  - CS goes all 1 and done=1 for exactly one cycle.
  - rx_data is updated in the same cycle; upper MAX_WIDTH-N bits are 0.
  - State GAP.
- At E0+(2N+2)*T: ready=1, state IDLE.
- Total start-to-done latency = (2N+1)*T cycles; the bench checks this exactly.
- start while ready=0 is ignored; no queuing.
- Input changes during a word have no effect (all inputs latched at E0).
- Boundaries:
  - word_len=0 gives a 1-bit word with 2 SCLK edges.
  - word_len=MAX_WIDTH-1 gives a full word.
  - clk_div=0 gives T=1 (SCLK = clk/2).
  - clk_div=all 1s gives T=2^DIV_W; the divider counter must not overflow.
- chip_addrs >= SLAVE_COUNT: no CS line asserts, but the word still runs and done pulses.
- The half-period counter reloads to clk_div at every phase boundary and counts down to 0; there is no free-running divider.

Optional Feature:
- Macro: SPI_MASTER_GEN_BURST_EN.
- Enabled:
  - Extra input hold_cs (1 bit), latched at E0.
  - If hold_cs=1, the word ends normally up to the done pulse, but CS stays low and the state enters BURST_WAIT with ready=1.
  - In BURST_WAIT, a new start skips SETUP: SCLK edge 1 occurs at E0+T, using the latched chip_addrs and ignoring the new chip_addrs; other inputs are latched as normal.
  - A burst word started with hold_cs=0 terminates normally (HOLD, CS high, GAP).
  - BURST_WAIT with no start holds CS low indefinitely; only rst exits it.
- Disabled: the hold_cs port is absent and CS is always released after every word.

Test Plan:
- Mode 0, N=8, clk_div=0, tx 0xA5, MISO tied to MOSI, chip_addrs=3 -> CS=8'hF7 for 17 cycles, 16 SCLK edges, done at E0+17, rx_data=0x000000A5, ready at E0+18.
- Mode 3, N=16, clk_div=3, lsb_first=1, tx 0x1234, slave model returns 0xBEEF LSB-first -> MOSI sequence 0,0,1,0,1,1,0,0,... ; rx_data=0x0000BEEF; done at E0+132.
- Modes 1 and 2, N=32, clk_div=1, tx 0xDEADBEEF, loopback -> rx_data=0xDEADBEEF; SCLK idles at CPOL before and after the word; MOSI=default_val outside SHIFT.
- word_len=0, tx 0x1, MISO=1 -> exactly 2 SCLK edges, rx_data=0x1, done at E0+3*T; a start pulse during GAP is ignored and no second word runs.
- rst asserted mid-word (edge 9 of 16) -> next clk: CS all 1, SCLK=CPOL, ready=1, no done pulse, rx_data unchanged; a following word completes correctly.
- With SPI_MASTER_GEN_BURST_EN: two words of 0x55 (hold_cs=1) then 0xAA (hold_cs=0) -> CS stays low across both, two done pulses, second word's edge 1 at its E0+T, CS high after the second word.
